// File: rtl/uart_rx_pkg.sv
// Shared types and helpers for the UART receiver.
package uart_rx_pkg;

  // Receive FSM states.
  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } rx_state_e;

  // Wide enough for 8 * 65535 - 1.
  localparam int unsigned CntW = 19;

  // A prescale of zero would stall the bit timer; run it as one instead.
  function automatic logic [15:0] eff_prescale(input logic [15:0] p);
    return (p == 16'd0) ? 16'd1 : p;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial input; idles high.
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q, sync_q;

  // Shift the pin through two flops; reset to the idle level.
  always_ff @(posedge clk) begin
    if (!rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART 8N1 receiver with run-time prescale and an AXI4-Stream master output.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rxd,
  input  logic [15:0]           prescale,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  busy,
  output logic                  overrun_error,
  output logic                  frame_error
);

  localparam int unsigned IdxW = $clog2(DATA_WIDTH + 1);

  logic rxd_s;

  uart_rx_sync u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rxd),
    .q   (rxd_s)
  );

  rx_state_e             state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [15:0]           pre_q, pre_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
  logic                  tvalid_q, tvalid_d;
  logic                  ovr_q, ovr_d;
  logic                  fe_q, fe_d;

  logic [15:0]     pre_eff;
  logic [CntW-1:0] half_len, bit_len;

  assign pre_eff  = eff_prescale(prescale);
  // Start is checked half a bit in, so every later sample lands mid-bit.
  assign half_len = {1'b0, pre_eff, 2'b00} - CntW'(1);
  assign bit_len  = {pre_q, 3'b000} - CntW'(1);

  // Next-state logic: bit timing, data assembly and stream handshake.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pre_d    = pre_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    tdata_d  = tdata_q;
    tvalid_d = tvalid_q;
    ovr_d    = 1'b0;
    fe_d     = 1'b0;

    if (tvalid_q && m_axis_tready) begin
      tvalid_d = 1'b0;
    end

    case (state_q)
      StIdle: begin
        if (!rxd_s) begin
          pre_d   = pre_eff;
          cnt_d   = half_len;
          state_d = StStart;
        end
      end
      StStart: begin
        if (cnt_q == '0) begin
          if (!rxd_s) begin
            cnt_d   = bit_len;
            idx_d   = '0;
            state_d = StData;
          end else begin
            // Start bit did not hold to its midpoint: treat as a glitch.
            state_d = StIdle;
          end
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StData: begin
        if (cnt_q == '0) begin
          // LSB arrives first, so shift in from the top.
          shift_d = (shift_q >> 1) | (DATA_WIDTH'(rxd_s) << (DATA_WIDTH - 1));
          cnt_d   = bit_len;
          if (idx_q == IdxW'(DATA_WIDTH - 1)) begin
            state_d = StStop;
          end else begin
            idx_d = idx_q + IdxW'(1);
          end
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StStop: begin
        if (cnt_q == '0) begin
          state_d = StIdle;
          if (rxd_s) begin
            tdata_d  = shift_q;
            tvalid_d = 1'b1;
            // A word that is being accepted this cycle is not lost.
            ovr_d    = tvalid_q && !m_axis_tready;
          end else begin
            fe_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      pre_q    <= 16'd1;
      idx_q    <= '0;
      shift_q  <= '0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      ovr_q    <= 1'b0;
      fe_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pre_q    <= pre_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
      ovr_q    <= ovr_d;
      fe_q     <= fe_d;
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign busy          = (state_q != StIdle);
  assign overrun_error = ovr_q;
  assign frame_error   = fe_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx.
module tb_uart_rx;

  logic        clk = 1'b0;
  logic        rst;
  logic        rxd;
  logic [15:0] prescale;
  logic [7:0]  m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        busy;
  logic        overrun_error;
  logic        frame_error;

  int checks = 0;
  int errors = 0;

  // Event counters maintained by the monitor.
  int valid_cyc = 0;
  int hs_cnt    = 0;
  int fe_cnt    = 0;
  int ov_cnt    = 0;
  logic [7:0] words[$];

  uart_rx #(.DATA_WIDTH(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .rxd           (rxd),
    .prescale      (prescale),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .busy          (busy),
    .overrun_error (overrun_error),
    .frame_error   (frame_error)
  );

  // 125 MHz.
  always #4 clk = ~clk;

  // Inputs change 2 ns after posedge, so negedge sees the values used at the next edge.
  always @(negedge clk) begin
    if (m_axis_tvalid === 1'b1) valid_cyc++;
    if (m_axis_tvalid === 1'b1 && m_axis_tready === 1'b1) begin
      hs_cnt++;
      words.push_back(m_axis_tdata);
    end
    if (frame_error === 1'b1) fe_cnt++;
    if (overrun_error === 1'b1) ov_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Drive frame bits first..last; frame = {stop, data, start}.
  task automatic send_bits(input logic [9:0] frame, input int first, input int last);
    for (int i = first; i <= last; i++) begin
      rxd = frame[i];
      wait_cyc(8 * int'(prescale));
    end
  endtask

  task automatic send_byte(input logic [7:0] data);
    send_bits({1'b1, data, 1'b0}, 0, 9);
  endtask

  int vb, hb, fb, ob, wb;
  logic [9:0] f;

  initial begin
    rst           = 1'b0;
    rxd           = 1'b1;
    prescale      = 16'd5;
    m_axis_tready = 1'b1;
    wait_cyc(5);
    check("reset_tdata", 32'(m_axis_tdata), 32'h0);
    check("reset_tvalid", 32'(m_axis_tvalid), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_errs", {30'b0, overrun_error, frame_error}, 32'h0);
    rst = 1'b1;
    wait_cyc(80);

    // Basic 0x55.
    vb = valid_cyc; hb = hs_cnt; fb = fe_cnt; ob = ov_cnt; wb = words.size();
    f = {1'b1, 8'h55, 1'b0};
    send_bits(f, 0, 4);
    check("basic_busy_mid", 32'(busy), 32'h1);
    send_bits(f, 5, 9);
    wait_cyc(20);
    check("basic_valid_cycles", 32'(valid_cyc - vb), 32'h1);
    check("basic_hs", 32'(hs_cnt - hb), 32'h1);
    if (words.size() > wb) check("basic_data", 32'(words[wb]), 32'h55);
    else check("basic_data_missing", 32'(words.size()), 32'(wb + 1));
    check("basic_fe", 32'(fe_cnt - fb), 32'h0);
    check("basic_ov", 32'(ov_cnt - ob), 32'h0);
    check("basic_busy_after", 32'(busy), 32'h0);

    // Frame error on 0xA3, then a clean 0x3C.
    vb = valid_cyc; fb = fe_cnt; ob = ov_cnt;
    send_bits({1'b0, 8'hA3, 1'b0}, 0, 9);
    rxd = 1'b1;
    wait_cyc(80);
    check("fe_pulse", 32'(fe_cnt - fb), 32'h1);
    check("fe_no_valid", 32'(valid_cyc - vb), 32'h0);
    check("fe_no_ov", 32'(ov_cnt - ob), 32'h0);
    hb = hs_cnt; wb = words.size();
    send_byte(8'h3C);
    wait_cyc(20);
    check("fe_next_hs", 32'(hs_cnt - hb), 32'h1);
    if (words.size() > wb) check("fe_next_data", 32'(words[wb]), 32'h3C);
    else check("fe_next_missing", 32'(words.size()), 32'(wb + 1));

    // Start glitch: 10 clocks low.
    vb = valid_cyc; fb = fe_cnt; ob = ov_cnt;
    rxd = 1'b0;
    wait_cyc(8);
    check("glitch_busy", 32'(busy), 32'h1);
    wait_cyc(2);
    rxd = 1'b1;
    wait_cyc(40);
    check("glitch_busy_clear", 32'(busy), 32'h0);
    check("glitch_no_valid", 32'(valid_cyc - vb), 32'h0);
    check("glitch_no_err", 32'((fe_cnt - fb) + (ov_cnt - ob)), 32'h0);

    // Backpressure and overrun.
    m_axis_tready = 1'b0;
    ob = ov_cnt; fb = fe_cnt; hb = hs_cnt;
    send_byte(8'h11);
    wait_cyc(10);
    check("bp_valid", 32'(m_axis_tvalid), 32'h1);
    check("bp_data1", 32'(m_axis_tdata), 32'h11);
    f = {1'b1, 8'h22, 1'b0};
    send_bits(f, 0, 5);
    check("bp_data_stable", 32'(m_axis_tdata), 32'h11);
    send_bits(f, 6, 9);
    wait_cyc(10);
    check("bp_overrun", 32'(ov_cnt - ob), 32'h1);
    check("bp_data2", 32'(m_axis_tdata), 32'h22);
    check("bp_valid2", 32'(m_axis_tvalid), 32'h1);
    wb = words.size();
    m_axis_tready = 1'b1;
    wait_cyc(1);
    check("bp_valid_drop", 32'(m_axis_tvalid), 32'h0);
    wait_cyc(5);
    check("bp_single_hs", 32'(hs_cnt - hb), 32'h1);
    if (words.size() > wb) check("bp_hs_data", 32'(words[wb]), 32'h22);
    else check("bp_hs_missing", 32'(words.size()), 32'(wb + 1));
    check("bp_no_fe", 32'(fe_cnt - fb), 32'h0);

    // Back-to-back at prescale 1 and 20.
    for (int k = 0; k < 2; k++) begin
      prescale = (k == 0) ? 16'd1 : 16'd20;
      wait_cyc(20);
      hb = hs_cnt; fb = fe_cnt; ob = ov_cnt; wb = words.size();
      send_byte(8'h00);
      send_byte(8'hFF);
      send_byte(8'h80);
      wait_cyc(20);
      check("b2b_hs", 32'(hs_cnt - hb), 32'h3);
      if (words.size() >= wb + 3) begin
        check("b2b_w0", 32'(words[wb]), 32'h00);
        check("b2b_w1", 32'(words[wb + 1]), 32'hFF);
        check("b2b_w2", 32'(words[wb + 2]), 32'h80);
      end else begin
        check("b2b_missing", 32'(words.size()), 32'(wb + 3));
      end
      check("b2b_err", 32'((fe_cnt - fb) + (ov_cnt - ob)), 32'h0);
    end

    // Reset during data bit 4, then 0x7E.
    prescale = 16'd5;
    wait_cyc(20);
    hb = hs_cnt; fb = fe_cnt; vb = valid_cyc;
    f = {1'b1, 8'h5A, 1'b0};
    send_bits(f, 0, 4);
    rxd = f[5];
    wait_cyc(20);
    rst = 1'b0;
    wait_cyc(2);
    check("rst_tdata", 32'(m_axis_tdata), 32'h0);
    check("rst_tvalid", 32'(m_axis_tvalid), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_errs", {30'b0, overrun_error, frame_error}, 32'h0);
    rxd = 1'b1;
    wait_cyc(4);
    rst = 1'b1;
    wait_cyc(80);
    check("rst_aborted_no_out", 32'(valid_cyc - vb), 32'h0);
    check("rst_aborted_no_fe", 32'(fe_cnt - fb), 32'h0);
    wb = words.size();
    send_byte(8'h7E);
    wait_cyc(20);
    check("rst_next_hs", 32'(hs_cnt - hb), 32'h1);
    if (words.size() > wb) check("rst_next_data", 32'(words[wb]), 32'h7E);
    else check("rst_next_missing", 32'(words.size()), 32'(wb + 1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
